// File: rtl/kernel_window_fetch_pkg.sv
// ============================================================================
// kernel_window_fetch_pkg : pooling constants shared with the pooling kernel
// Revision : 1.0
// ============================================================================
`default_nettype none

package kernel_window_fetch_pkg;

  localparam int WIN_SIZE    = 3;
  localparam int NUM_TAPS    = WIN_SIZE * WIN_SIZE;
  localparam int POOL_DWIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } fetch_state_t;

  // Number of window positions along one axis of the output grid.
  function automatic int out_dim(input int img, input int stride);
    return (img - WIN_SIZE) / stride + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kernel_window_fetch.sv
// ============================================================================
// kernel_window_fetch : scans a frame in BRAM, emitting 3x3 strided windows
// Revision : 1.0
// ============================================================================
`default_nettype none

module kernel_window_fetch
  import kernel_window_fetch_pkg::*;
#(
  parameter int DWIDTH    = POOL_DWIDTH,
  parameter int IMG_W     = 12,
  parameter int IMG_H     = 12,
  parameter int STRIDE    = 3,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     bram_en,
  output logic [ADDR_W-1:0]        bram_addr,
  input  logic [DWIDTH-1:0]        bram_dout,
  output logic [NUM_TAPS*DWIDTH-1:0] win_data,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [7:0]               win_row,
  output logic [7:0]               win_col,
  output logic                     busy,
  output logic                     done
);

  localparam int OUT_W = out_dim(IMG_W, STRIDE);
  localparam int OUT_H = out_dim(IMG_H, STRIDE);

  fetch_state_t r_state, w_next;

  logic [3:0]                 r_tap;
  logic [1:0]                 r_tap_r;
  logic [1:0]                 r_tap_c;
  logic                       r_cap_vld;
  logic [3:0]                 r_cap_idx;
  logic [NUM_TAPS*DWIDTH-1:0] r_win;
  logic [7:0]                 r_row;
  logic [7:0]                 r_col;

  logic                       w_hs;
  logic                       w_last;
  logic [ADDR_W-1:0]          w_addr;

  assign w_hs   = (r_state == ST_OUT) && win_ready;
  assign w_last = (r_row == 8'(OUT_H - 1)) && (r_col == 8'(OUT_W - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_next = ST_FETCH;
      ST_FETCH: if (r_tap == 4'(NUM_TAPS - 1)) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_OUT;
      ST_OUT:   if (win_ready) w_next = w_last ? ST_DONE : ST_FETCH;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Address math is deliberately modular in ADDR_W bits.
  always_comb begin
    w_addr = ADDR_W'(BASE_ADDR)
           + (ADDR_W'(r_row) * ADDR_W'(STRIDE) + ADDR_W'(r_tap_r)) * ADDR_W'(IMG_W)
           + ADDR_W'(r_col) * ADDR_W'(STRIDE) + ADDR_W'(r_tap_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tap     <= '0;
      r_tap_r   <= '0;
      r_tap_c   <= '0;
      r_cap_vld <= 1'b0;
      r_cap_idx <= '0;
      r_win     <= '0;
      r_row     <= '0;
      r_col     <= '0;
    end else begin
      // Read data lands one cycle after its tap, so slot capture trails the issue.
      r_cap_vld <= (r_state == ST_FETCH);
      r_cap_idx <= r_tap;
      if (r_cap_vld) r_win[r_cap_idx*DWIDTH +: DWIDTH] <= bram_dout;

      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_tap   <= '0;
            r_tap_r <= '0;
            r_tap_c <= '0;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        ST_FETCH: begin
          r_tap <= r_tap + 4'd1;
          if (r_tap_c == 2'(WIN_SIZE - 1)) begin
            r_tap_c <= '0;
            r_tap_r <= r_tap_r + 2'd1;
          end else begin
            r_tap_c <= r_tap_c + 2'd1;
          end
        end
        ST_OUT: begin
          if (w_hs) begin
            r_tap   <= '0;
            r_tap_r <= '0;
            r_tap_c <= '0;
            if (r_col == 8'(OUT_W - 1)) begin
              r_col <= '0;
              r_row <= r_row + 8'd1;
            end else begin
              r_col <= r_col + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bram_en   = (r_state == ST_FETCH);
  assign bram_addr = bram_en ? w_addr : '0;
  assign win_valid = (r_state == ST_OUT);
  assign win_data  = r_win;
  assign win_row   = r_row;
  assign win_col   = r_col;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: doc/kernel_window_fetch.md
KERNEL_WINDOW_FETCH -- requirements
Module: kernel_window_fetch

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 12: image width in pixels.
REQ-003 SHALL have parameter IMG_H, default 12: image height in pixels.
REQ-004 SHALL have parameter STRIDE, default 3: window step in both axes.
REQ-005 SHALL have parameter ADDR_W, default 8: BRAM address width.
REQ-006 SHALL have parameter BASE_ADDR, default 0: BRAM address of pixel (0,0).
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port start, input, 1 bit: begin a frame scan; sampled only in IDLE.
REQ-010 SHALL have port bram_en, output, 1 bit: BRAM read enable.
REQ-011 SHALL have port bram_addr, output, ADDR_W bits: BRAM read address.
REQ-012 SHALL have port bram_dout, input, DWIDTH bits: BRAM read data, valid one cycle after bram_en.
REQ-013 SHALL have port win_data, output, 9*DWIDTH bits: packed 3x3 window; pixel (r,c) in bits [(r*3+c)*DWIDTH +: DWIDTH], the packing the pooling kernel expects.
REQ-014 SHALL have port win_valid, output, 1 bit: win_data is valid.
REQ-015 SHALL have port win_ready, input, 1 bit: consumer accepts win_data.
REQ-016 SHALL have port win_row, output, 8 bits: output-grid row index of the current window.
REQ-017 SHALL have port win_col, output, 8 bits: output-grid column index of the current window.
REQ-018 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-019 SHALL have port done, output, 1 bit: one-cycle pulse after the last window handshake.

Function
REQ-020 SHALL implement states IDLE, FETCH, DRAIN, OUT and DONE.
REQ-021 SHALL move IDLE->FETCH on start=1, clearing the window and tap counters to 0.
REQ-022 SHALL in FETCH assert bram_en for exactly 9 cycles with tap k=0..8 at address BASE_ADDR + (r0+k/3)*IMG_W + (c0+k%3), where r0=win_row*STRIDE and c0=win_col*STRIDE.
REQ-023 SHALL register bram_dout into window slot k one cycle after tap k is issued.
REQ-024 SHALL move FETCH->DRAIN after tap 8; DRAIN captures slot 8 with bram_en=0, then moves to OUT.
REQ-025 SHALL hold win_valid=1 in OUT, keeping win_data, win_row and win_col stable until win_valid&&win_ready.
REQ-026 SHALL on handshake advance win_col; when win_col wraps from OUT_W-1 to 0, advance win_row.
REQ-027 SHALL define OUT_W=(IMG_W-3)/STRIDE+1 and OUT_H=(IMG_H-3)/STRIDE+1, using integer division.
REQ-028 SHALL on handshake move to FETCH for the next window, or to DONE if the window at (OUT_H-1, OUT_W-1) was accepted.
REQ-029 SHALL in DONE assert done=1 for one cycle, then return to IDLE.
REQ-030 SHALL ignore start in every state except IDLE.
REQ-031 SHALL make win_valid assert exactly 11 cycles after the edge sampling start: 9 FETCH cycles, 1 DRAIN cycle, then OUT.
REQ-032 SHALL drive win_valid=0 and bram_en=0 in every state except OUT and FETCH respectively.
REQ-033 SHALL truncate the address arithmetic to ADDR_W bits; no out-of-range checking.

Reset
REQ-034 SHALL on rst=1 at any clock edge, including mid-fetch or mid-OUT, go to IDLE with bram_en=0, bram_addr=0, win_valid=0, win_data=0, win_row=0, win_col=0, busy=0 and done=0.
REQ-035 SHALL give rst priority over start, win_ready and all state transitions.

Structure
REQ-036 SHALL take the window size (3), the tap count (9) and the DWIDTH default from the shared pooling constants package, which is also used by the pooling kernel.
REQ-037 SHALL be a single module; the FSM, tap counter and window counters live inline; no sub-module.

Verification
REQ-038 SHALL cover first window: BRAM[a]=a, defaults, pulse start -> win_valid at cycle 11 with win_data=72'h1A_19_18_0E_0D_0C_02_01_00 and win_row=0, win_col=0.
REQ-039 SHALL cover the second-row window: same image, accept windows until win_row=1, win_col=1 -> win_data=72'h41_40_3F_35_34_33_29_28_27.
REQ-040 SHALL cover full frame: win_ready tied high -> exactly 16 handshakes; the last has win_data=72'h8F_8E_8D_83_82_81_77_76_75, followed by one done pulse, then busy=0.
REQ-041 SHALL cover backpressure: win_ready=0 for 20 cycles in OUT -> win_data, win_row and win_col stable, bram_en=0 throughout, and no window lost.
REQ-042 SHALL cover reset mid-fetch: rst at tap 4 of window 2 -> all outputs at reset values next cycle; a new start then restarts at window (0,0).
REQ-043 SHALL cover start while busy: start pulsed during FETCH -> ignored, and the total window count stays 16.
